// File: rtl/fpu_byte_loader_pkg.sv
// Shared types for the byte-serial FPU front end.
// Opcodes, loader states and the default word width.
package fpu_pkg;

  localparam int FP_W = 16;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_CMP
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ISSUE,
    S_WAIT,
    S_SEND
  } ld_state_e;

endpackage

// File: rtl/fpu_byte_loader_if.sv
// Operand/result handshake bundle between the loader and the FPU core.
// The loader is the master; the core is the slave.
interface fpu_byte_loader_if
  import fpu_pkg::*;
#(
  parameter int W = FP_W
);

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [1:0]   opcode;
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] res_in;
  logic         res_valid;
  logic         res_ready;

  modport master (
    output op_a,
    output op_b,
    output opcode,
    output op_valid,
    output res_ready,
    input  op_ready,
    input  res_in,
    input  res_valid
  );

  modport slave (
    input  op_a,
    input  op_b,
    input  opcode,
    input  op_valid,
    input  res_ready,
    output op_ready,
    output res_in,
    output res_valid
  );

endinterface

// File: rtl/fpu_byte_loader_shreg.sv
// W-bit register with parallel load and byte-wide shift toward the MSB.
// Shifting in fills the LSB byte; the MSB byte falls off the top.
module fpu_byte_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         shift_i,
  input  logic [7:0]   byte_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_data_i;
    end else if (shift_i) begin
      q_d = (q_q << 8) | W'(byte_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fpu_byte_loader.sv
// Byte-serial loader: command + two operands in, core handshake,
// then the result streamed back out MSB byte first.
module fpu_byte_loader
  import fpu_pkg::*;
#(
  parameter int W = FP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_byte,
  input  logic               in_strobe,
  fpu_byte_loader_if.master  core,
  output logic [7:0]         out_byte,
  output logic               busy,
  output logic               drop
);

  localparam int NB = W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  ld_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_e           opc_q, opc_d;
  logic          drop_q, drop_d;

  logic sh_a, sh_b, res_ld, res_sh;
  logic [W-1:0] a_q, b_q, res_q;
  logic unused_res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opc_d   = opc_q;
    drop_d  = drop_q;
    sh_a    = 1'b0;
    sh_b    = 1'b0;
    res_ld  = 1'b0;
    res_sh  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_strobe) begin
          opc_d   = op_e'(in_byte[1:0]);
          cnt_d   = '0;
          drop_d  = 1'b0;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (in_strobe) begin
          sh_a  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end
        end
      end
      S_LOAD_B: begin
        if (in_strobe) begin
          sh_b  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (in_strobe) drop_d = 1'b1;
        if (core.op_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (in_strobe) drop_d = 1'b1;
        if (core.res_valid) begin
          res_ld  = 1'b1;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (in_strobe) begin
          res_sh = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opc_q   <= OP_ADD;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      drop_q  <= drop_d;
    end
  end

  fpu_byte_shreg #(.W(W)) u_op_a (
    .clk         (clk),
    .rst         (rst),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (sh_a),
    .byte_i      (in_byte),
    .q_o         (a_q)
  );

  fpu_byte_shreg #(.W(W)) u_op_b (
    .clk         (clk),
    .rst         (rst),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (sh_b),
    .byte_i      (in_byte),
    .q_o         (b_q)
  );

  // Result is shifted toward the MSB so the top byte is always the one shown.
  fpu_byte_shreg #(.W(W)) u_res (
    .clk         (clk),
    .rst         (rst),
    .load_i      (res_ld),
    .load_data_i (core.res_in),
    .shift_i     (res_sh),
    .byte_i      (8'h00),
    .q_o         (res_q)
  );

  assign unused_res = ^res_q;

  assign core.op_a      = a_q;
  assign core.op_b      = b_q;
  assign core.opcode    = opc_q;
  assign core.op_valid  = (state_q == S_ISSUE);
  assign core.res_ready = (state_q == S_WAIT);

  assign out_byte = (state_q == S_SEND) ? res_q[W-1 -: 8] : 8'h00;
  assign busy     = (state_q != S_IDLE);
  assign drop     = drop_q;

endmodule
